mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter_pkg.sv | 13 +
 rtl/mem_port_arbiter_rr_pick2.sv | 22 ++
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared encodings for the memory port arbiter
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      RESP  = 2'b10
   } state_t;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_IO  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// rtl/mem_port_arbiter_rr_pick2.sv - combinational 2-way round-robin selector
module rr_pick2
   import mem_port_arbiter_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic last_served,
   output logic valid,
   output logic winner
);

   always_comb begin
      valid  = req0 | req1;
      winner = PORT_CPU;
      if (req0 && req1) begin
         winner = ~last_served;
      end else if (req1) begin
         winner = PORT_IO;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin single-port RAM arbiter with bounded lock bursts
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int AW       = 8,
   parameter int DW       = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req0,
   input  logic          we0,
   input  logic          lock0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   output logic          gnt0,
   output logic          ack0,
   input  logic          req1,
   input  logic          we1,
   input  logic          lock1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          gnt1,
   output logic          ack1,
   output logic [DW-1:0] rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          owner
);

   localparam int            HW       = $clog2(MAX_HOLD) + 1;
   localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD - 1);
   localparam logic [HW-1:0] HOLD_SAT = '1;

   state_t        state_q, state_d;
   logic          owner_q, owner_d;
   logic          last_q, last_d;
   logic [HW-1:0] hold_q, hold_d;
   logic          pick_valid, pick_winner;
   logic          own_req, own_lock, oth_req;
   logic          issue, resp;

   rr_pick2 u_pick (
      .req0        (req0),
      .req1        (req1),
      .last_served (last_q),
      .valid       (pick_valid),
      .winner      (pick_winner)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         owner_q <= PORT_CPU;
         last_q  <= PORT_IO;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
      end
   end

   always_comb begin
      own_req  = owner_q ? req1 : req0;
      own_lock = owner_q ? lock1 : lock0;
      oth_req  = owner_q ? req0 : req1;
      state_d  = state_q;
      owner_d  = owner_q;
      last_d   = last_q;
      hold_d   = hold_q;
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               state_d = ISSUE;
               owner_d = pick_winner;
               last_d  = pick_winner;
            end
         end
         ISSUE: state_d = RESP;
         RESP: begin
            // the owner's req is stale here unless it also holds lock
            if (own_lock && own_req && (!oth_req || hold_q < HOLD_LIM)) begin
               state_d = ISSUE;
               last_d  = owner_q;
               if (hold_q != HOLD_SAT) hold_d = hold_q + 1'b1;
            end else if (oth_req) begin
               state_d = ISSUE;
               owner_d = ~owner_q;
               last_d  = ~owner_q;
               hold_d  = '0;
            end else begin
               state_d = IDLE;
               hold_d  = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      issue     = (state_q == ISSUE);
      resp      = (state_q == RESP);
      gnt0      = issue && (owner_q == PORT_CPU);
      gnt1      = issue && (owner_q == PORT_IO);
      ack0      = resp && (owner_q == PORT_CPU);
      ack1      = resp && (owner_q == PORT_IO);
      owner     = (issue || resp) && owner_q;
      mem_en    = issue;
      mem_we    = issue && (owner_q ? we1 : we0);
      mem_addr  = issue ? (owner_q ? addr1 : addr0) : '0;
      mem_wdata = issue ? (owner_q ? wdata1 : wdata0) : '0;
      rdata     = resp ? mem_rdata : '0;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

   localparam int AW       = 8;
   localparam int DW       = 8;
   localparam int MAX_HOLD = 4;

   typedef struct {
      int         gap;
      bit         we;
      bit         lock;
      logic [7:0] addr;
      logic [7:0] wdata;
   } txn_t;

   typedef struct {
      bit         we;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] rdata;
   } exp_t;

   typedef struct {
      int cyc;
      bit port;
      bit is_ack;
   } ev_t;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_d[2];
   logic       we_d[2];
   logic       lock_d[2];
   logic [7:0] addr_d[2];
   logic [7:0] wdata_d[2];
   logic       gnt0, gnt1, ack0, ack1, owner, mem_en, mem_we;
   logic [7:0] rdata, mem_addr, mem_wdata;
   logic [7:0] mem_rdata = '0;

   logic [7:0] ram[256];
   logic [7:0] shadow[256];
   bit         ram_ready = 1'b0;

   txn_t scr[2][$];
   exp_t expq[2][$];
   ev_t  evlog[$];

   int         n_checks = 0;
   int         n_err    = 0;
   int         cyc_cnt  = 0;
   int         we_cycles = 0;
   int         wait_cnt[2];
   logic [7:0] last_rdata[2];
   bit         acked[2];
   bit         prev_g[2];
   bit         mon_g[2];
   bit         mon_a[2];
   exp_t       mon_e;
   int         t0;

   mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req0      (req_d[0]),
      .we0       (we_d[0]),
      .lock0     (lock_d[0]),
      .addr0     (addr_d[0]),
      .wdata0    (wdata_d[0]),
      .gnt0      (gnt0),
      .ack0      (ack0),
      .req1      (req_d[1]),
      .we1       (we_d[1]),
      .lock1     (lock_d[1]),
      .addr1     (addr_d[1]),
      .wdata1    (wdata_d[1]),
      .gnt1      (gnt1),
      .ack1      (ack1),
      .rdata     (rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .owner     (owner)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   function automatic logic [7:0] init_val(input int i);
      return 8'(i) ^ 8'h4A;
   endfunction

   // RAM with one-cycle read latency; preloaded during the first reset cycle
   always @(posedge clk) begin
      if (!ram_ready) begin
         for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
         ram_ready <= 1'b1;
      end else if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         mem_rdata <= ram[mem_addr];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   // monitor: pops the scoreboard on every grant/ack the DUT presents
   always @(negedge clk) begin
      mon_g[0] = gnt0; mon_g[1] = gnt1;
      mon_a[0] = ack0; mon_a[1] = ack1;
      if (mem_we) we_cycles++;
      if (!rst_n) begin
         wait_cnt[0] = 0; wait_cnt[1] = 0;
         prev_g[0] = 1'b0; prev_g[1] = 1'b0;
      end else begin
         chk("bus_consistency", {gnt0 & gnt1, mem_en, mem_we & ~mem_en}, {1'b0, gnt0 | gnt1, 1'b0});
         for (int p = 0; p < 2; p++) begin
            if (!req_d[1-p]) wait_cnt[1-p] = 0;
            if (mon_g[p]) begin
               evlog.push_back('{cyc_cnt, p[0], 1'b0});
               chk("gnt_has_expectation", 32'(expq[p].size() != 0), 1);
               if (expq[p].size() != 0) begin
                  mon_e = expq[p][0];
                  chk("gnt_addr", mem_addr, mon_e.addr);
                  chk("gnt_we", mem_we, mon_e.we);
                  if (mon_e.we) chk("gnt_wdata", mem_wdata, mon_e.wdata);
                  chk("gnt_owner", owner, p);
               end
               if (req_d[1-p]) begin
                  wait_cnt[1-p]++;
                  chk("fair_wait_bound", 32'(wait_cnt[1-p] <= MAX_HOLD), 1);
               end
               wait_cnt[p] = 0;
            end
            if (mon_a[p]) begin
               evlog.push_back('{cyc_cnt, p[0], 1'b1});
               chk("ack_follows_gnt", prev_g[p], 1);
               chk("ack_has_expectation", 32'(expq[p].size() != 0), 1);
               if (expq[p].size() != 0) begin
                  mon_e = expq[p].pop_front();
                  chk("ack_owner", owner, p);
                  if (!mon_e.we) chk("read_data", rdata, mon_e.rdata);
               end
               last_rdata[p] = rdata;
            end
            prev_g[p] = mon_g[p];
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input int p, input int gap, input bit we, input bit lock,
                      input logic [7:0] addr, input logic [7:0] wdata);
      scr[p].push_back('{gap, we, lock, addr, wdata});
   endtask

   task automatic push_exp(input int p, input bit we, input logic [7:0] addr, input logic [7:0] wdata);
      exp_t e;
      e.we = we; e.addr = addr; e.wdata = wdata; e.rdata = shadow[addr];
      if (we) shadow[addr] = wdata;
      expq[p].push_back(e);
   endtask

   task automatic load(input int p);
      txn_t t;
      t = scr[p].pop_front();
      req_d[p]   = 1'b1;
      we_d[p]    = t.we;
      addr_d[p]  = t.addr;
      wdata_d[p] = t.wdata;
      // lock only when the next access follows back-to-back
      lock_d[p]  = t.lock && scr[p].size() > 0 && scr[p][0].gap == 0;
      acked[p]   = 1'b0;
      push_exp(p, t.we, t.addr, t.wdata);
   endtask

   // drives both port scripts; called and returns at posedge+1
   task automatic run(input string name, input int budget);
      bit   active[2];
      bit   done;
      int   n;
      txn_t t;
      active[0] = 1'b0; active[1] = 1'b0;
      acked[0] = 1'b0; acked[1] = 1'b0;
      done = 1'b0; n = 0;
      while (!done && n < budget) begin
         for (int p = 0; p < 2; p++) begin
            if (active[p]) begin
               if (acked[p]) begin
                  acked[p] = 1'b0;
                  if (scr[p].size() > 0 && scr[p][0].gap == 0) load(p);
                  else begin
                     req_d[p] = 1'b0; lock_d[p] = 1'b0; active[p] = 1'b0;
                  end
               end
            end else if (scr[p].size() > 0) begin
               if (scr[p][0].gap <= 0) begin
                  load(p); active[p] = 1'b1;
               end else begin
                  t = scr[p][0]; t.gap--; scr[p][0] = t;
               end
            end
         end
         done = !active[0] && !active[1] && scr[0].size() == 0 && scr[1].size() == 0;
         if (!done) begin
            @(negedge clk);
            acked[0] = ack0; acked[1] = ack1;
            step();
            n++;
         end
      end
      chk({name, "_completed"}, done, 1);
      if (!done) begin
         for (int p = 0; p < 2; p++) begin
            scr[p].delete(); expq[p].delete();
            req_d[p] = 1'b0; lock_d[p] = 1'b0;
         end
      end
   endtask

   task automatic chk_ev(input string name, input int idx, input int rel, input int port, input int is_ack);
      if (evlog.size() > idx)
         chk(name, (evlog[idx].cyc - t0) * 4 + int'(evlog[idx].port) * 2 + int'(evlog[idx].is_ack),
             rel * 4 + port * 2 + is_ack);
      else
         chk(name, evlog.size(), idx + 1);
   endtask

   task automatic check_zero(input string name);
      chk(name, {gnt0, gnt1, ack0, ack1, owner, mem_en, mem_we, mem_addr, mem_wdata, rdata}, 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step(); step();
      rst_n = 1'b1;
   endtask

   initial begin
      int n0, n_after, bad, first1, f, a0, a1, prev_c, g, cnt;
      bit prev_p, have_prev;
      for (int p = 0; p < 2; p++) begin
         req_d[p] = 1'b0; we_d[p] = 1'b0; lock_d[p] = 1'b0;
         addr_d[p] = '0; wdata_d[p] = '0; last_rdata[p] = '0;
      end
      for (int i = 0; i < 256; i++) shadow[i] = init_val(i);

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_zero("reset_outputs");
      step();
      rst_n = 1'b1;

      // single read of a preloaded word
      evlog.delete(); t0 = cyc_cnt;
      add(0, 0, 1'b0, 1'b0, 8'h10, 8'h00);
      run("t1", 50);
      chk_ev("t1_gnt_cycle", 0, 1, 0, 0);
      chk_ev("t1_ack_cycle", 1, 2, 0, 1);
      chk("t1_rdata", last_rdata[0], 8'h5A);
      @(negedge clk);
      chk("t1_back_to_idle", {gnt0, gnt1, ack0, ack1, mem_en, mem_we}, 0);
      step();

      // simultaneous requests right after reset
      do_reset();
      evlog.delete(); t0 = cyc_cnt;
      add(0, 0, 1'b0, 1'b0, 8'h11, 8'h00);
      add(1, 0, 1'b0, 1'b0, 8'h12, 8'h00);
      run("t2", 50);
      chk_ev("t2_gnt0", 0, 1, 0, 0);
      chk_ev("t2_ack0", 1, 2, 0, 1);
      chk_ev("t2_gnt1", 2, 3, 1, 0);
      chk_ev("t2_ack1", 3, 4, 1, 1);

      // port 1 write, then port 0 reads it back
      we_cycles = 0;
      add(1, 0, 1'b1, 1'b0, 8'h22, 8'hC3);
      run("t3w", 50);
      chk("t3_we_cycles", we_cycles, 1);
      add(0, 0, 1'b0, 1'b0, 8'h22, 8'h00);
      run("t3r", 50);
      chk("t3_readback", last_rdata[0], 8'hC3);

      // locked burst on port 0 with port 1 arriving during the first access
      evlog.delete();
      for (int i = 0; i < 12; i++) add(0, 0, 1'b0, 1'b1, 8'(8'h30 + i), 8'h00);
      add(1, 1, 1'b0, 1'b0, 8'h40, 8'h00);
      run("t4", 200);
      n0 = 0; n_after = 0; bad = 0; first1 = -1; prev_c = 0;
      for (int i = 0; i < evlog.size(); i++) begin
         if (!evlog[i].is_ack) begin
            if (evlog[i].port && first1 < 0) begin
               first1 = i; prev_c = evlog[i].cyc;
            end else if (!evlog[i].port && first1 < 0) n0++;
            else if (!evlog[i].port) begin
               n_after++;
               if (evlog[i].cyc - prev_c != 2) bad++;
               prev_c = evlog[i].cyc;
            end
         end
      end
      chk("t4_locked_before_switch", n0, MAX_HOLD);
      chk("t4_burst_after_switch", n_after, 8);
      chk("t4_burst_spacing", bad, 0);

      // both ports requesting continuously without lock
      evlog.delete();
      for (int i = 0; i < 10; i++) begin
         add(0, 0, 1'b0, 1'b0, 8'(8'h60 + i), 8'h00);
         add(1, 0, 1'b0, 1'b0, 8'(8'h90 + i), 8'h00);
      end
      run("t5", 200);
      g = 0; bad = 0; f = -1; have_prev = 1'b0; prev_p = 1'b0; prev_c = 0;
      for (int i = 0; i < evlog.size(); i++) begin
         if (!evlog[i].is_ack) begin
            g++;
            if (f < 0) f = evlog[i].cyc;
            if (have_prev && (evlog[i].port == prev_p || evlog[i].cyc - prev_c != 2)) bad++;
            have_prev = 1'b1; prev_p = evlog[i].port; prev_c = evlog[i].cyc;
         end
      end
      a0 = 0; a1 = 0;
      for (int i = 0; i < evlog.size(); i++) begin
         if (evlog[i].is_ack && evlog[i].cyc >= f + 1 && evlog[i].cyc <= f + 16) begin
            if (evlog[i].port) a1++; else a0++;
         end
      end
      chk("t5_grants", g, 20);
      chk("t5_alternation", bad, 0);
      chk("t5_ack0_per_16", a0, 4);
      chk("t5_ack1_per_16", a1, 4);

      // reset while port 1 is in ISSUE
      step();
      req_d[1] = 1'b1; we_d[1] = 1'b0; addr_d[1] = 8'h50; lock_d[1] = 1'b0;
      push_exp(1, 1'b0, 8'h50, 8'h00);
      step();
      step();
      rst_n = 1'b0;
      step();
      @(negedge clk);
      check_zero("t6_reset_outputs");
      expq[1].delete();
      req_d[1] = 1'b0;
      step();
      rst_n = 1'b1;
      evlog.delete(); t0 = cyc_cnt;
      add(0, 0, 1'b0, 1'b0, 8'h51, 8'h00);
      add(1, 0, 1'b0, 1'b0, 8'h52, 8'h00);
      run("t6", 50);
      chk_ev("t6_first_grant_port0", 0, 1, 0, 0);

      // randomized traffic on disjoint address halves
      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < 40; i++) begin
            cnt = ($urandom_range(0, 9) < 5) ? 0 : int'($urandom_range(1, 3));
            add(p, cnt, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                p == 1 ? 8'($urandom_range(128, 255)) : 8'($urandom_range(0, 127)),
                8'($urandom));
         end
      end
      run("random", 5000);
      chk("scoreboard_drained", expq[0].size() + expq[1].size(), 0);

      repeat (2) step();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
      $fatal(1, "watchdog");
   end

endmodule
